pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Next-generation hazard/stall controller for the LC-3b pipeline.
- Replaces the single-bit valid scoreboard with per-register pending-write counters, so several in-flight writes to one register are tracked correctly.
- Adds a data-memory handshake FSM for single- and double-access ops (LDI/STI).
- Generates all pipeline-stage load enables, the decode NOP-insert, and the fetch read request.
- Sits between decode/WB control and the two memory ports.

Parameters:
NUM_REGS, 8, number of architectural registers tracked
REG_IDX_W, 3, register index width (clog2 NUM_REGS)
MAX_PENDING, 3, maximum in-flight writes per register; counter width CNT_W = clog2(MAX_PENDING+1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode stage holds a real instruction
dec_uses_sr1  in  1  decode instruction reads sr1
dec_sr1  in  REG_IDX_W  source register 1 index
dec_uses_sr2  in  1  decode instruction reads sr2
dec_sr2  in  REG_IDX_W  source register 2 index
dec_uses_dest  in  1  decode instruction writes dest
dec_dest  in  REG_IDX_W  destination index
wb_valid  in  1  WB stage holds a real instruction
wb_uses_dest  in  1  WB instruction writes a register
wb_dest  in  REG_IDX_W  WB destination index
imem_resp  in  1  instruction memory response
dmem_read  in  1  MEM stage data read request
dmem_write  in  1  MEM stage data write request
dmem_multi  in  1  MEM op needs two accesses (LDI/STI)
dmem_resp  in  1  data memory response
imem_read  out  1  instruction fetch request (registered)
load_pc, load_de  out  1  front-end advance enables
load_ex, load_mem, load_wb  out  1  back-end advance enables
insert_nop  out  1  inject bubble into EX
hazard_stall  out  1  data or pending-limit hazard this cycle
err_underflow  out  1  sticky: retire seen on a zero counter

Behaviour:
- Reset (rst_n low, async): all counters 0; FSM MEM_IDLE; imem_read 1; err_underflow 0. All load_* and insert_nop are forced 0 while rst_n is low.
- mem_req = dmem_read | dmem_write.
- FSM states:
  - MEM_IDLE: mem_req goes to MEM_ACC1.
  - MEM_ACC1: dmem_resp with dmem_multi goes to MEM_ACC2. dmem_resp without dmem_multi goes to MEM_IDLE.
  - MEM_ACC2: dmem_resp goes to MEM_IDLE.
- mem_done = dmem_resp in the final access state (ACC1 with !dmem_multi, or ACC2).
- memory_stall = mem_req & !mem_done.
- load_register = imem_resp & !memory_stall.
- Pending condition for a source register r: cnt[r] != 0.
- data_hazard = (dec_uses_sr1 & pending(sr1)) | (dec_uses_sr2 & pending(sr2)).
- limit_hazard = dec_uses_dest & cnt[dec_dest] == MAX_PENDING.
- hazard_stall = dec_valid & (data_hazard | limit_hazard).
- Stage enables:
  - load_pc = load_de = load_register & !hazard_stall.
  - load_ex = load_mem = load_wb = load_register.
  - insert_nop = hazard_stall.
- Counter update:
  - issue = load_pc & dec_valid & dec_uses_dest increments cnt[dec_dest].
  - retire = load_wb & wb_valid & wb_uses_dest decrements cnt[wb_dest].
  - Issue and retire to the same register in one cycle: net no change.
  - Retire on cnt == 0: counter stays 0 and err_underflow is set (cleared only by reset).
  - Counters never exceed MAX_PENDING; limit_hazard blocks the issue that would overflow.
- imem_read:
  - Cleared the cycle after imem_resp.
  - Otherwise set the cycle after load_register.
  - Otherwise holds.
  - imem_resp takes priority over load_register.
- Reset asserted mid-transaction: FSM returns to IDLE immediately. In-flight memory ops are abandoned; the pipeline must be flushed externally.

Optional Feature:
WB_BYPASS_EN
- Defined: a source register is not pending if cnt[r] == 1 and a retire to r occurs this cycle. The register file is write-through, so the value is available and the stall is removed one cycle earlier.
- Undefined: the pending condition is strictly cnt[r] != 0.

Decomposition:
- Shared package lc3b_types gains:
  - hz_mem_state_e enum (MEM_IDLE, MEM_ACC1, MEM_ACC2).
  - Constants LC3B_NUM_REGS = 8 and LC3B_MAX_PENDING = 3.
- Sub-module reg_pending_scoreboard holds the counter array, the issue/retire ports, the pending vector output and the underflow flag.
- The FSM and enable logic stay in pipeline_hazard_ctrl.

Test Plan:
1. Reset release with imem_resp=1, no requests and no hazards -> all load_* = 1, imem_read = 1 at reset; imem_read = 0 the cycle after the first imem_resp.
2. Issue ADD R3 (cnt[3] -> 1), then decode reads R3 -> hazard_stall = 1, insert_nop = 1, load_pc = 0 until WB retires R3. Without the macro, load_pc resumes the cycle after retire; with WB_BYPASS_EN, it resumes in the retire cycle.
3. Issue three writes to R1 with no retire (cnt[1] = 3), then a fourth instruction writes R1 -> limit_hazard stalls and cnt[1] stays 3.
4. LDI: dmem_read = 1, dmem_multi = 1, resp after 2 cycles then 3 cycles -> IDLE -> ACC1 -> ACC2 -> IDLE; all load_* = 0 until the second resp cycle.
5. Issue and retire to R5 in the same cycle with cnt[5] = 1 -> cnt[5] stays 1. Retire R6 with cnt[6] = 0 -> err_underflow = 1 and sticky.
6. rst_n pulsed low in MEM_ACC1 -> FSM goes IDLE asynchronously, counters 0, outputs 0 during reset.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: memory handshake states and pipeline-wide constants.
package lc3b_types;

    localparam int LC3B_NUM_REGS    = 8;
    localparam int LC3B_MAX_PENDING = 3;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_ACC1 = 2'd1,
        MEM_ACC2 = 2'd2
    } hz_mem_state_e;

endpackage

// File: rtl/reg_pending_scoreboard.sv
// Per-register pending-write counters with issue/retire ports and sticky underflow flag.
// Optional macro: WB_BYPASS_EN (a register whose last pending write retires this
// cycle is reported as not pending, relying on the write-through register file).
module reg_pending_scoreboard
    import lc3b_types::*;
#(
    parameter int NUM_REGS    = LC3B_NUM_REGS,
    parameter int REG_IDX_W   = 3,
    parameter int MAX_PENDING = LC3B_MAX_PENDING
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_idx,
    input  logic                 retire,
    input  logic [REG_IDX_W-1:0] retire_idx,
    output logic [NUM_REGS-1:0]  pending,
    output logic [NUM_REGS-1:0]  at_limit,
    output logic                 err_underflow
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_underflow_q;
    logic             err_underflow_d;
    logic             inc;
    logic             dec;

    // Pending and at-limit flags seen by the decode stage
    always_comb begin
        pending  = '0;
        at_limit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pending[i] = (cnt_q[i] != '0);
`ifdef WB_BYPASS_EN
            if (cnt_q[i] == CNT_W'(1) && retire && retire_idx == REG_IDX_W'(i)) begin
                pending[i] = 1'b0;
            end
`endif
            at_limit[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    // Counter next-state: matching issue and retire cancel, retire at zero flags underflow
    always_comb begin
        err_underflow_d = err_underflow_q;
        inc             = 1'b0;
        dec             = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            inc      = issue  && (issue_idx  == REG_IDX_W'(i));
            dec      = retire && (retire_idx == REG_IDX_W'(i));
            if (dec && !inc) begin
                if (cnt_q[i] == '0) begin
                    err_underflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end else if (inc && !dec && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_underflow_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_underflow = err_underflow_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// LC-3b hazard/stall controller: data-memory handshake FSM, stage enables,
// decode NOP insert and fetch request, around the pending-write scoreboard.
// Optional macro: WB_BYPASS_EN (passed through to reg_pending_scoreboard).
module pipeline_hazard_ctrl
    import lc3b_types::*;
#(
    parameter int NUM_REGS    = LC3B_NUM_REGS,
    parameter int REG_IDX_W   = 3,
    parameter int MAX_PENDING = LC3B_MAX_PENDING
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    input  logic                 dec_uses_sr1,
    input  logic [REG_IDX_W-1:0] dec_sr1,
    input  logic                 dec_uses_sr2,
    input  logic [REG_IDX_W-1:0] dec_sr2,
    input  logic                 dec_uses_dest,
    input  logic [REG_IDX_W-1:0] dec_dest,
    input  logic                 wb_valid,
    input  logic                 wb_uses_dest,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_multi,
    input  logic                 dmem_resp,
    output logic                 imem_read,
    output logic                 load_pc,
    output logic                 load_de,
    output logic                 load_ex,
    output logic                 load_mem,
    output logic                 load_wb,
    output logic                 insert_nop,
    output logic                 hazard_stall,
    output logic                 err_underflow
);

    hz_mem_state_e        state_q;
    hz_mem_state_e        state_d;
    logic                 imem_read_q;
    logic                 imem_read_d;
    logic                 mem_req;
    logic                 mem_done;
    logic                 memory_stall;
    logic                 load_register;
    logic                 data_hazard;
    logic                 limit_hazard;
    logic                 issue;
    logic                 retire;
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  at_limit;

    reg_pending_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_IDX_W   (REG_IDX_W),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue         (issue),
        .issue_idx     (dec_dest),
        .retire        (retire),
        .retire_idx    (wb_dest),
        .pending       (pending),
        .at_limit      (at_limit),
        .err_underflow (err_underflow)
    );

    // Data-memory handshake next state and final-access detection
    always_comb begin
        state_d  = state_q;
        mem_done = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_req) state_d = MEM_ACC1;
            end
            MEM_ACC1: begin
                if (dmem_resp) begin
                    if (dmem_multi) begin
                        state_d = MEM_ACC2;
                    end else begin
                        state_d  = MEM_IDLE;
                        mem_done = 1'b1;
                    end
                end
            end
            MEM_ACC2: begin
                if (dmem_resp) begin
                    state_d  = MEM_IDLE;
                    mem_done = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Memory stall, global advance, retire strobe and fetch-request next value.
    // Retire is kept apart from the hazard logic: with the bypass, pending depends on it.
    always_comb begin
        mem_req       = dmem_read | dmem_write;
        memory_stall  = mem_req & ~mem_done;
        load_register = imem_resp & ~memory_stall;
        retire        = rst_n & load_register & wb_valid & wb_uses_dest;
        if (imem_resp) begin
            imem_read_d = 1'b0;
        end else if (load_register) begin
            imem_read_d = 1'b1;
        end else begin
            imem_read_d = imem_read_q;
        end
    end

    // Hazard detection and stage enables, all enables held low during reset
    always_comb begin
        data_hazard  = (dec_uses_sr1 & pending[dec_sr1]) | (dec_uses_sr2 & pending[dec_sr2]);
        limit_hazard = dec_uses_dest & at_limit[dec_dest];
        hazard_stall = dec_valid & (data_hazard | limit_hazard);
        load_pc      = rst_n & load_register & ~hazard_stall;
        load_de      = load_pc;
        load_ex      = rst_n & load_register;
        load_mem     = load_ex;
        load_wb      = load_ex;
        insert_nop   = rst_n & hazard_stall;
    end

    // Issue strobe into the scoreboard
    always_comb begin
        issue = load_pc & dec_valid & dec_uses_dest;
    end

    // FSM state and fetch-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MEM_IDLE;
            imem_read_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            imem_read_q <= imem_read_d;
        end
    end

    assign imem_read = imem_read_q;

endmodule
